// File: rtl/dcache_wt_if.sv
// CPU load/store port plus backing-memory handshake for the write-through data cache.
// The master side (CPU pipeline plus memory) drives requests and memory responses.
interface dcache_wt_if;
    logic [31:0] addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output addr, re, we, wdata, mem_rdata, mem_ready,
        input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  addr, re, we, wdata, mem_rdata, mem_ready,
        output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Read hits return combinationally; misses fill a full line and stores always go to memory.
module dcache_wt #(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 8,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    dcache_wt_if.slave  io_bus
);
    localparam int W       = $clog2(LINE_WORDS);
    localparam int S       = $clog2(SETS);
    localparam int IDX_LSB = 2 + W;
    localparam int TAG_LSB = 2 + W + S;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam logic [W-1:0] LAST_WORD = W'(LINE_WORDS - 1);
    localparam logic [W-1:0] ONE       = W'(1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t                r_state;
    logic [W-1:0]          r_fillCnt;
    logic [SETS-1:0]       r_valid;
    logic [TAG_W-1:0]      r_tag  [SETS];
    logic [DATA_WIDTH-1:0] r_data [SETS][LINE_WORDS];
    logic                  r_memReq;
    logic                  r_memWe;
    logic [31:0]           r_memAddr;
    logic [DATA_WIDTH-1:0] r_memWdata;

    logic [W-1:0]          w_offset;
    logic [S-1:0]          w_index;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_hit;
    logic [W-1:0]          w_nextCnt;
    logic                  w_stall;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_offset  = io_bus.addr[IDX_LSB-1:2];
    assign w_index   = io_bus.addr[TAG_LSB-1:IDX_LSB];
    assign w_tag     = io_bus.addr[31:TAG_LSB];
    assign w_hit     = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_nextCnt = r_fillCnt + ONE;

    // The CPU holds addr stable while stalled, so its index/tag address the line being filled or written.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == FILL && io_bus.mem_ready) begin
                r_data[w_index][r_fillCnt] <= io_bus.mem_rdata;
                if (r_fillCnt == LAST_WORD) begin
                    r_tag[w_index] <= w_tag;
                end
            end
            if (r_state == WRITE && io_bus.mem_ready && w_hit) begin
                r_data[w_index][w_offset] <= io_bus.wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fillCnt  <= '0;
            r_valid    <= '0;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_bus.we) begin
                        r_state    <= WRITE;
                        r_memReq   <= 1'b1;
                        r_memWe    <= 1'b1;
                        r_memAddr  <= {io_bus.addr[31:2], 2'b00};
                        r_memWdata <= io_bus.wdata;
                    end else if (io_bus.re && !w_hit) begin
                        r_state   <= FILL;
                        r_fillCnt <= '0;
                        r_memReq  <= 1'b1;
                        r_memWe   <= 1'b0;
                        r_memAddr <= {io_bus.addr[31:IDX_LSB], {W{1'b0}}, 2'b00};
                    end
                end
                FILL: begin
                    if (io_bus.mem_ready) begin
                        r_fillCnt <= w_nextCnt;
                        r_memAddr <= {r_memAddr[31:IDX_LSB], w_nextCnt, 2'b00};
                        // Valid only once the last word lands, so a partial line never hits.
                        if (r_fillCnt == LAST_WORD) begin
                            r_valid[w_index] <= 1'b1;
                            r_state          <= IDLE;
                            r_memReq         <= 1'b0;
                            r_memAddr        <= '0;
                        end
                    end
                end
                WRITE: begin
                    if (io_bus.mem_ready) begin
                        r_state    <= IDLE;
                        r_memReq   <= 1'b0;
                        r_memWe    <= 1'b0;
                        r_memAddr  <= '0;
                        r_memWdata <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_stall = 1'b0;
        w_rdata = '0;
        case (r_state)
            IDLE: begin
                if (io_bus.we) begin
                    w_stall = 1'b1;
                end else if (io_bus.re) begin
                    if (w_hit) begin
                        w_rdata = r_data[w_index][w_offset];
                    end else begin
                        w_stall = 1'b1;
                    end
                end
            end
            FILL:    w_stall = 1'b1;
            WRITE:   w_stall = !io_bus.mem_ready;
            default: w_stall = 1'b0;
        endcase
    end

    assign io_bus.stall     = w_stall;
    assign io_bus.rdata     = w_rdata;
    assign io_bus.mem_req   = r_memReq;
    assign io_bus.mem_we    = r_memWe;
    assign io_bus.mem_addr  = r_memAddr;
    assign io_bus.mem_wdata = r_memWdata;
endmodule
